// File: rtl/instruction_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   The fetch stage drives the word address; memory returns the word with a
//   purely combinational read of that address.
//
//   Signals:
//     imem_addr   32  fetch address (the current PC)
//     imem_rdata  32  instruction word stored at imem_addr
//
//   Modports:
//     master  fetch-stage side (drives imem_addr, receives imem_rdata)
//     slave   memory side      (receives imem_addr, drives imem_rdata)
// ----------------------------------------------------------------------------
interface instruction_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//   MIPS instruction fetch stage together with the IF/ID pipeline register.
//   Holds the PC, drives the instruction-memory address, chooses the next PC
//   from sequential / branch / jump / jump-register sources, and latches the
//   fetched word into IF/ID. Supports stall (hold) and flush (insert NOP).
//   There is no branch delay slot: every redirect squashes the younger fetch.
//
//   Ports:
//     Clk            in   1   rising-edge clock
//     Reset          in   1   synchronous active-high reset
//     Stall          in   1   hold PC and IF/ID
//     BranchTaken    in   1   branch resolved taken in EX (oldest redirect)
//     BranchTarget   in   32  branch destination
//     Jump           in   1   J/JAL/JR decoded in ID
//     JumpIndex      in   26  instr[25:0] of the jump in ID
//     JumpReg        in   1   jump is a JR (target from JumpRegAddr)
//     JumpRegAddr    in   32  rs value for JR
//     imem           if       instruction-memory bus (master modport)
//     IF_ID_Instr    out  32  latched instruction
//     IF_ID_PCPlus4  out  32  PC+4 of the latched instruction
//     IF_ID_Valid    out  1   latched instruction is real (0 = bubble)
//     opcode         out  6   IF_ID_Instr[31:26]
//     functionCode   out  6   IF_ID_Instr[5:0]
//     rt             out  5   IF_ID_Instr[20:16]
//     FetchCount     out  32  instructions accepted into IF/ID since reset
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Stall,
  input  logic                              BranchTaken,
  input  logic [31:0]                       BranchTarget,
  input  logic                              Jump,
  input  logic [25:0]                       JumpIndex,
  input  logic                              JumpReg,
  input  logic [31:0]                       JumpRegAddr,
  instruction_fetch_stage_if.master         imem,
  output logic [31:0]                       IF_ID_Instr,
  output logic [31:0]                       IF_ID_PCPlus4,
  output logic                              IF_ID_Valid,
  output logic [5:0]                        opcode,
  output logic [5:0]                        functionCode,
  output logic [4:0]                        rt,
  output logic [31:0]                       FetchCount
);

  logic [31:0] pc_q,          pc_d;
  logic [31:0] ifid_instr_q,  ifid_instr_d;
  logic [31:0] ifid_pc4_q,    ifid_pc4_d;
  logic        ifid_valid_q,  ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4_s;
  logic        jump_s;
  logic        unused_bits_s;

  // Sequential increment; 32'hFFFF_FFFC naturally wraps to 0.
  assign pc_plus4_s = pc_q + 32'd4;

  // A jump is only honoured when the instruction in ID is real; a bubble
  // cannot have decoded a jump.
  assign jump_s = Jump & ifid_valid_q;

  // Low address bits of redirect targets are forced to zero (word aligned).
  assign unused_bits_s = ^{BranchTarget[1:0], JumpRegAddr[1:0]};

  // Next-state selection: reset is handled in the register block, the rest
  // follows branch > jump > stall > sequential priority.
  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (BranchTaken) begin
      // Branch is older than anything in ID, so it beats a concurrent jump.
      pc_d         = {BranchTarget[31:2], 2'b00};
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (jump_s) begin
      if (JumpReg) begin
        pc_d = {JumpRegAddr[31:2], 2'b00};
      end else begin
        // Region bits come from the PC+4 of the jump itself, now in IF/ID.
        pc_d = {ifid_pc4_q[31:28], JumpIndex, 2'b00};
      end
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (Stall) begin
      pc_d = pc_q;
    end else begin
      pc_d          = pc_plus4_s;
      ifid_instr_d  = imem.imem_rdata;
      ifid_pc4_d    = pc_plus4_s;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q          <= RESET_PC;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign IF_ID_Instr    = ifid_instr_q;
  assign IF_ID_PCPlus4  = ifid_pc4_q;
  assign IF_ID_Valid    = ifid_valid_q;
  assign FetchCount     = fetch_count_q;

  // Decode fields are plain slices of the latched word.
  assign opcode         = ifid_instr_q[31:26];
  assign functionCode   = ifid_instr_q[5:0];
  assign rt             = ifid_instr_q[20:16];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   all compared against a cycle-level reference model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic [4:0]  rt;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_cnt;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .Clk          (clk),
    .Reset        (reset),
    .Stall        (stall),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Jump         (jump),
    .JumpIndex    (jump_index),
    .JumpReg      (jump_reg),
    .JumpRegAddr  (jump_reg_addr),
    .imem         (bus),
    .IF_ID_Instr  (if_id_instr),
    .IF_ID_PCPlus4(if_id_pc4),
    .IF_ID_Valid  (if_id_valid),
    .opcode       (opcode),
    .functionCode (function_code),
    .rt           (rt),
    .FetchCount   (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: 32'h2008_0005 at address 0, ascending after.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 + {2'b00, a[31:2]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, compare.
  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic [31:0] btgt, input logic jmp,
                      input logic [25:0] jidx, input logic jr,
                      input logic [31:0] jraddr);
    logic [31:0] n_pc, n_instr, n_pc4, n_cnt;
    logic        n_valid;
    reset = rst; stall = st; branch_taken = bt; branch_target = btgt;
    jump = jmp; jump_index = jidx; jump_reg = jr; jump_reg_addr = jraddr;

    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; n_cnt = 32'h0;
    end else if (bt || (jmp && m_valid)) begin
      if (bt)      n_pc = btgt & 32'hFFFF_FFFC;
      else if (jr) n_pc = jraddr & 32'hFFFF_FFFC;
      else         n_pc = (m_pc4 & 32'hF000_0000) | ({6'd0, jidx} * 32'd4);
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
    end else if (!st) begin
      n_instr = mem_word(m_pc);
      n_pc    = m_pc + 32'd4;
      n_pc4   = n_pc;
      n_valid = 1'b1;
      n_cnt   = m_cnt + 32'd1;
    end

    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
    check_eq("imem_addr",    bus.imem_addr,          m_pc);
    check_eq("IF_ID_Instr",  if_id_instr,            m_instr);
    check_eq("IF_ID_PCPlus4", if_id_pc4,             m_pc4);
    check_eq("IF_ID_Valid",  {31'd0, if_id_valid},   {31'd0, m_valid});
    check_eq("FetchCount",   fetch_count,            m_cnt);
    check_eq("opcode",       {26'd0, opcode},        {26'd0, m_instr[31:26]});
    check_eq("functionCode", {26'd0, function_code}, {26'd0, m_instr[5:0]});
    check_eq("rt",           {27'd0, rt},            {27'd0, m_instr[20:16]});
  endtask

  task automatic run(input logic st);
    step(1'b0, st, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 26'h5, 1'b0, 32'h0);
    check_eq("reset_addr", bus.imem_addr, 32'h0);
    check_eq("reset_valid", {31'd0, if_id_valid}, 32'h0);

    // Free running from address 0
    run(1'b0);
    check_eq("first_opcode", {26'd0, opcode}, 32'h0000_0008);
    check_eq("first_pc4", if_id_pc4, 32'h4);
    check_eq("first_instr", if_id_instr, 32'h2008_0005);
    run(1'b0);
    check_eq("addr_8", bus.imem_addr, 32'h8);

    // Stall two cycles at PC = 8, then resume without skip or duplicate
    run(1'b1);
    run(1'b1);
    check_eq("stall_addr", bus.imem_addr, 32'h8);
    check_eq("stall_cnt", fetch_count, 32'd2);
    run(1'b0);
    check_eq("resume_addr", bus.imem_addr, 32'hC);
    check_eq("resume_instr", if_id_instr, 32'h2008_0007);
    check_eq("resume_cnt", fetch_count, 32'd3);

    // Branch during stall: redirect wins, low bits cleared
    step(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0, 26'h0, 1'b0, 32'h0);
    check_eq("br_addr", bus.imem_addr, 32'h40);
    check_eq("br_valid", {31'd0, if_id_valid}, 32'h0);

    // Jump while IF/ID holds a bubble is ignored
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3F, 1'b0, 32'h0);
    check_eq("jmp_bubble_addr", bus.imem_addr, 32'h44);

    // Place IF_ID_PCPlus4 = 1000_0010, then J with index 0x100
    step(1'b0, 1'b0, 1'b1, 32'h1000_000C, 1'b0, 26'h0, 1'b0, 32'h0);
    run(1'b0);
    check_eq("j_setup_pc4", if_id_pc4, 32'h1000_0010);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b0, 32'h0);
    check_eq("j_addr", bus.imem_addr, 32'h1000_0400);
    check_eq("j_flush", if_id_instr, 32'h0);
    run(1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b1, 32'h0000_0080);
    check_eq("jr_addr", bus.imem_addr, 32'h80);

    // Jump and branch together: branch wins
    run(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 26'h2AA_AAAA, 1'b0, 32'h0);
    check_eq("br_over_j", bus.imem_addr, 32'h20);

    // PC wrap at the top of the address space
    run(1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0, 1'b1, 32'hFFFF_FFFC);
    run(1'b0);
    check_eq("wrap_addr", bus.imem_addr, 32'h0);

    // Reset during a redirect
    run(1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 26'h1, 1'b1, 32'h200);
    check_eq("rst_redir_addr", bus.imem_addr, 32'h0);
    check_eq("rst_redir_cnt", fetch_count, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 5) == 0), 26'($urandom),
           1'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. It holds the PC, drives the instruction-memory address, and selects the next PC from sequential, branch, jump and jump-register sources. It latches the fetched word into the IF/ID register, which feeds the opcode, functionCode and rt fields to the Controller and register file. It supports stall (hold) and flush (insert NOP) for the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or reset (sll $0,$0,0)
- Clk  input  1  rising-edge clock; the only clock
- Reset  input  1  synchronous, active-high reset, sampled on rising Clk
- Stall  input  1  hold PC and IF/ID contents (load-use hazard)
- BranchTaken  input  1  branch resolved taken in EX
- BranchTarget  input  32  branch destination from EX
- Jump  input  1  J/JAL decoded in ID
- JumpIndex  input  26  instr[25:0] of the jump in ID
- JumpReg  input  1  JR decoded in ID (qualifies Jump)
- JumpRegAddr  input  32  rs value for JR
- imem_addr  output  32  instruction-memory address (= PC)
- imem_rdata  input  32  instruction word; combinational read of imem_addr
- IF_ID_Instr  output  32  latched instruction
- IF_ID_PCPlus4  output  32  PC+4 of the latched instruction
- IF_ID_Valid  output  1  1 = latched instruction is real, 0 = bubble
- opcode  output  6  IF_ID_Instr[31:26]
- functionCode  output  6  IF_ID_Instr[5:0]
- rt  output  5  IF_ID_Instr[20:16]
- FetchCount  output  32  count of instructions accepted into IF/ID

## Operation
- No branch delay slot. Redirects squash younger instructions.
- Next-PC priority, highest first:
  - Reset: PC ← RESET_PC.
  - BranchTaken: PC ← {BranchTarget[31:2],2'b00}.
  - Jump & JumpReg: PC ← {JumpRegAddr[31:2],2'b00}.
  - Jump & !JumpReg: PC ← {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - Stall: PC held.
  - Otherwise: PC ← PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update uses the same priority order:
  - Reset: Instr ← NOP_INSTR, PCPlus4 ← 0, Valid ← 0.
  - BranchTaken or Jump (flush): Instr ← NOP_INSTR, PCPlus4 ← 0, Valid ← 0.
  - Stall: all IF/ID fields held.
  - Otherwise: Instr ← imem_rdata, PCPlus4 ← PC+4, Valid ← 1.
- A redirect overrides a simultaneous Stall. The PC and IF/ID still redirect and flush.
- A Jump asserted together with BranchTaken is ignored, because the branch is older.
- The Jump input must be gated by IF_ID_Valid upstream. This block also ignores Jump while IF_ID_Valid = 0.
- FetchCount increments by 1 on each edge where IF/ID loads with Valid ← 1. It clears on Reset and wraps at 2^32.
- opcode, functionCode and rt are pure slices of IF_ID_Instr, with no extra logic.

## Timing
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, IF_ID_Instr = NOP_INSTR, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0, FetchCount = 0. Derived fields opcode, functionCode and rt are all 0.
- First cycle after Reset deasserts: imem_addr = RESET_PC. On the next edge, IF/ID holds the word at RESET_PC and PC = RESET_PC+4.
- Fetch-to-decode latency is 1 cycle. imem_addr changes only on a rising Clk.
- A redirect asserted in cycle N gives imem_addr = target in cycle N+1. IF_ID_Valid = 0 in cycle N+1.
- Stall held for k cycles freezes all outputs for k cycles. Fetch resumes on the first edge where Stall = 0.
- Reset mid-stall or mid-redirect wins unconditionally on that edge.
- All state updates on the rising Clk only. No combinational path from any input to imem_addr.

## Test plan
- **Reset, then 4 free-running cycles:** imem returns 32'h2008_0005 at address 0 and ascending words after it. Expect imem_addr 0,4,8,C. Expect IF_ID_PCPlus4 = 4 when opcode = 6'b001000. Expect FetchCount = 3 at cycle 4.
- **Stall for 2 cycles at PC = 8:** Expect imem_addr held at 8. Expect IF_ID_Instr/PCPlus4/Valid unchanged. Expect FetchCount unchanged. Fetch resumes at 8 with no skip or duplicate.
- **BranchTaken with BranchTarget = 32'h0000_0043 while Stall = 1:** Expect next imem_addr = 32'h40. Expect IF_ID_Valid = 0 and IF_ID_Instr = 0.
- **Jump in ID:** IF_ID_PCPlus4 = 32'h1000_0010, JumpIndex = 26'h000_0100. Expect next PC = 32'h1000_0400 and IF/ID flushed. Repeat with JumpReg = 1 and JumpRegAddr = 32'h0000_0080: expect PC = 32'h80.
- **Jump and BranchTaken in the same cycle:** BranchTarget = 32'h20, JumpIndex nonzero. Expect PC = 32'h20.
- **PC wrap and reset mid-run:** Set PC = 32'hFFFF_FFFC and step once: expect PC = 0. Then assert Reset during a redirect: expect PC = RESET_PC and all outputs at reset values on that edge.
